// File: rtl/memory_access_pkg.sv
// memory_access_pkg: FSM state encoding, operation type and default timing constants
package memory_access_pkg;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [1:0] S_ERR    = 2'd3;
  typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} op_e;
  localparam int WAIT_STATES_DEF    = 1;
  localparam int TIMEOUT_CYCLES_DEF = 16;
  localparam int CNT_W              = 8;
endpackage

// File: rtl/memory_access_wait_counter.sv
// memory_access_wait_counter: loadable down-counter with terminal-count flag
module memory_access_wait_counter
  import memory_access_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] count_o,
  output logic             tc_o
);
  logic [CNT_W-1:0] count_q, count_d;
  always_comb count_d = load_i ? load_val_i : (en_i && count_q != '0) ? count_q - CNT_W'(1) : count_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else count_q <= count_d;
  assign count_o = count_q;
  assign tc_o    = count_q == '0;
endmodule

// File: rtl/memory_access_controller.sv
// memory_access_controller: single-word bus master toward MAIN_MEMORY with wait states.
// Define MEMORY_ACCESS_ACK_EN to complete accesses on MEM_ACK_In with a timeout.
module memory_access_controller
  import memory_access_pkg::*;
#(
  parameter int DATAWIDTH_BUS  = 32,
  parameter int WAIT_STATES    = WAIT_STATES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                     MEMORY_ACCESS_CLOCK_50,
  input  logic                     MEMORY_ACCESS_RESET_InLow,
  input  logic                     CPU_REQ_In,
  input  logic                     CPU_RD_In,
  input  logic                     CPU_WR_In,
  input  logic [DATAWIDTH_BUS-1:0] CPU_ADDRESS_InBUS,
  input  logic [DATAWIDTH_BUS-1:0] CPU_data_InBUS,
  output logic [DATAWIDTH_BUS-1:0] CPU_data_OutBUS,
  output logic                     CPU_DONE_Out,
  output logic                     CPU_ERROR_Out,
  output logic                     CPU_BUSY_Out,
  output logic [DATAWIDTH_BUS-1:0] MEM_ADDRESS_OutBUS,
  output logic [DATAWIDTH_BUS-1:0] MEM_data_OutBUS,
  output logic                     MEM_RD_Out,
  output logic                     MEM_WR_Out,
  input  logic [DATAWIDTH_BUS-1:0] MEM_data_InBUS,
  input  logic                     MEM_ACK_In
);
  logic [1:0] state_q, state_d;
  logic [DATAWIDTH_BUS-1:0] addr_q, wdata_q, rdata_q, rdata_d;
  op_e op_q, op_d;
  logic rd_q, wr_q, req_ok, accept, in_access, leave_ok, leave_err, cnt_tc;
  logic [CNT_W-1:0] cnt, cnt_load_val;
  assign req_ok    = (CPU_RD_In ^ CPU_WR_In) && CPU_ADDRESS_InBUS[1:0] == 2'b00;
  assign accept    = state_q == S_IDLE && CPU_REQ_In && req_ok;
  assign in_access = state_q == S_ACCESS;
`ifdef MEMORY_ACCESS_ACK_EN
  // Counter runs the whole timeout window; elapsed cycles are derived from what remains.
  assign cnt_load_val = CNT_W'(TIMEOUT_CYCLES - 1);
  assign leave_ok     = MEM_ACK_In && cnt <= CNT_W'(TIMEOUT_CYCLES - 1 - WAIT_STATES);
  assign leave_err    = cnt_tc && !leave_ok;
`else
  logic unused_ack;
  assign unused_ack   = ^{cnt, MEM_ACK_In};
  assign cnt_load_val = CNT_W'(WAIT_STATES);
  assign leave_ok     = cnt_tc;
  assign leave_err    = 1'b0;
`endif
  memory_access_wait_counter u_cnt (
    .clk        (MEMORY_ACCESS_CLOCK_50),
    .rst_n      (MEMORY_ACCESS_RESET_InLow),
    .load_i     (accept),
    .en_i       (in_access),
    .load_val_i (cnt_load_val),
    .count_o    (cnt),
    .tc_o       (cnt_tc)
  );
  always_comb begin
    state_d = state_q == S_IDLE   ? (CPU_REQ_In ? (req_ok ? S_ACCESS : S_ERR) : S_IDLE) :
              state_q == S_ACCESS ? (leave_ok ? S_DONE : leave_err ? S_ERR : S_ACCESS) : S_IDLE;
    op_d    = accept ? (CPU_WR_In ? OP_WR : OP_RD) : op_q;
    rdata_d = (in_access && leave_ok && op_q == OP_RD) ? MEM_data_InBUS :
              (in_access && leave_err) ? '0 : rdata_q;
  end
  always_ff @(posedge MEMORY_ACCESS_CLOCK_50 or negedge MEMORY_ACCESS_RESET_InLow)
    if (!MEMORY_ACCESS_RESET_InLow) begin
      state_q <= S_IDLE;
      op_q    <= OP_RD;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rdata_q <= rdata_d;
      rd_q    <= state_d == S_ACCESS && op_d == OP_RD;
      wr_q    <= state_d == S_ACCESS && op_d == OP_WR;
      if (accept) begin
        addr_q  <= CPU_ADDRESS_InBUS;
        wdata_q <= CPU_data_InBUS;
      end
    end
  assign CPU_data_OutBUS    = rdata_q;
  assign CPU_DONE_Out       = state_q == S_DONE || state_q == S_ERR;
  assign CPU_ERROR_Out      = state_q == S_ERR;
  assign CPU_BUSY_Out       = state_q != S_IDLE;
  assign MEM_ADDRESS_OutBUS = addr_q;
  assign MEM_data_OutBUS    = wdata_q;
  assign MEM_RD_Out         = rd_q;
  assign MEM_WR_Out         = wr_q;
endmodule

// File: tb/tb_memory_access_controller.sv
// tb_memory_access_controller: randomized scoreboard bench with a behavioural memory model
module tb_memory_access_controller;
  localparam int WS = 1;
  localparam int TO = 16;
`ifdef MEMORY_ACCESS_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif
  typedef struct {
    logic err;
    logic [31:0] data, addr, wdata;
    int delta, rds, wrs, issue;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b1, req = 1'b0, rd = 1'b0, wr = 1'b0, ack_noise = 1'b0;
  logic [31:0] addr = '0, wdata = '0, mem_din = '0, last_rd = '0;
  logic [31:0] cpu_dout, mem_addr, mem_dout;
  logic done, err, busy, mem_rd, mem_wr, mem_ack;
  logic [100:0] outs;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  exp_t sb[$];
  int vectors = 0, miscompares = 0, cyc = 0, scnt = 0, ack_at_v = WS + 1, rd_c = 0, wr_c = 0;
  logic abad = 1'b0;

  memory_access_controller #(.DATAWIDTH_BUS(32), .WAIT_STATES(WS), .TIMEOUT_CYCLES(TO)) dut (
    .MEMORY_ACCESS_CLOCK_50    (clk),
    .MEMORY_ACCESS_RESET_InLow (rst_n),
    .CPU_REQ_In                (req),
    .CPU_RD_In                 (rd),
    .CPU_WR_In                 (wr),
    .CPU_ADDRESS_InBUS         (addr),
    .CPU_data_InBUS            (wdata),
    .CPU_data_OutBUS           (cpu_dout),
    .CPU_DONE_Out              (done),
    .CPU_ERROR_Out             (err),
    .CPU_BUSY_Out              (busy),
    .MEM_ADDRESS_OutBUS        (mem_addr),
    .MEM_data_OutBUS           (mem_dout),
    .MEM_RD_Out                (mem_rd),
    .MEM_WR_Out                (mem_wr),
    .MEM_data_InBUS            (mem_din),
    .MEM_ACK_In                (mem_ack)
  );

  always #5 clk = ~clk;
  assign outs    = {cpu_dout, done, err, busy, mem_addr, mem_dout, mem_rd, mem_wr};
  assign mem_ack = ACK ? ((mem_rd || mem_wr) && scnt + 1 >= ack_at_v) : ack_noise;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a == 32'h0 ? 32'h10800800 : a == 32'h800 ? 32'hC6002001 : {a[15:0], ~a[15:0]} ^ 32'h3C5A96E1;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // MAIN_MEMORY stand-in: data presented mid-cycle, writes committed while strobed
  always @(posedge clk) begin
    cyc <= cyc + 1;
    scnt <= (mem_rd || mem_wr) ? scnt + 1 : 0;
  end
  always @(negedge clk) begin
    mem_din = mem.exists(mem_addr) ? mem[mem_addr] : init_word(mem_addr);
    if (mem_wr) mem[mem_addr] = mem_dout;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      rd_c = 0; wr_c = 0; abad = 1'b0;
    end else begin
      if (mem_rd) rd_c++;
      if (mem_wr) wr_c++;
      if ((mem_rd || mem_wr) && sb.size() > 0 &&
          (mem_addr !== sb[0].addr || (mem_wr && mem_dout !== sb[0].wdata))) abad = 1'b1;
      if (done) begin
        if (sb.size() == 0) chk("done_without_request", 128'(sb.size()), 128'd1);
        else begin
          e = sb.pop_front();
          chk("error", 128'(err), 128'(e.err));
          chk("rdata", 128'(cpu_dout), 128'(e.data));
          chk("latency", 128'(cyc - e.issue), 128'(e.delta));
          chk("rd_strobes", 128'(rd_c), 128'(e.rds));
          chk("wr_strobes", 128'(wr_c), 128'(e.wrs));
          chk("mem_bus_stable", 128'(abad), 128'd0);
          chk("busy", 128'(busy), 128'd1);
        end
        rd_c = 0; wr_c = 0; abad = 1'b0;
      end
    end
  end

  task automatic run(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d, input int ack_at);
    exp_t e;
    logic ok, tmo;
    int s;
    ok  = (r ^ w) && a[1:0] == 2'b00;
    tmo = ok && ACK && ack_at > TO;
    s   = !ok ? 0 : tmo ? TO : (ACK && ack_at > WS + 1) ? ack_at : WS + 1;
    if (tmo) last_rd = '0;
    else if (ok && r) last_rd = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    else if (ok) ref_mem[a] = d;
    e.err = !ok || tmo; e.data = last_rd; e.addr = a; e.wdata = d;
    e.delta = s; e.rds = (ok && r) ? s : 0; e.wrs = (ok && w) ? s : 0; e.issue = cyc + 1;
    sb.push_back(e);
    ack_at_v = ack_at;
    req = 1'b1; rd = r; wr = w; addr = a; wdata = d;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        @(negedge clk);
        return;
      end
      // operands thrown at the DUT while busy must be ignored
      req = 1'($urandom); rd = 1'($urandom); wr = 1'($urandom);
      addr = $urandom; wdata = $urandom; ack_noise = 1'($urandom);
    end
    miscompares++;
    $display("FAIL done_timeout: got no DONE expected DONE within 40 cycles");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "bench stopped: DUT never completed");
  endtask

  initial begin
    logic [31:0] a;
    int sel;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 128'(outs), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run(1'b1, 1'b0, 32'h800, 32'h0, WS + 1);
    run(1'b1, 1'b0, 32'h0, 32'h0, WS + 1);
    run(1'b0, 1'b1, 32'h804, 32'hDEADBEEF, WS + 1);
    run(1'b1, 1'b0, 32'h802, 32'h0, WS + 1);
    run(1'b1, 1'b1, 32'h800, 32'h0, WS + 1);
    run(1'b0, 1'b0, 32'h800, 32'h0, WS + 1);
    run(1'b1, 1'b0, 32'h804, 32'h0, WS + 1);
    req = 1'b1; rd = 1'b1; wr = 1'b0; addr = 32'h808;
    @(negedge clk);
    req = 1'b0;
    chk("rd_before_reset", 128'(mem_rd), 128'd1);
    #2 rst_n = 1'b0;
    #1 chk("abort_outputs", 128'(outs), 128'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    last_rd = '0;
    @(negedge clk);
    run(1'b1, 1'b0, 32'h808, 32'h0, WS + 1);
    for (int n = 0; n < 60; n++) begin
      a = 32'h800 + 32'(4 * $urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      sel = $urandom_range(0, 9);
      run(sel == 0 || (sel > 1 && sel[0]), sel == 0 || (sel > 1 && !sel[0]), a, $urandom, $urandom_range(1, 5));
      repeat ($urandom_range(0, 2)) begin
        req = 1'b0;
        @(negedge clk);
      end
    end
    if (ACK) begin
      run(1'b1, 1'b0, 32'h800, 32'h0, 100);
      run(1'b1, 1'b0, 32'h800, 32'h0, 4);
    end
    req = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 128'(sb.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/memory_access_controller.md
Name: memory_access_controller

Overview:
- Sequential bus master sitting directly upstream of MAIN_MEMORY; the CPU control unit issues single-word read/write requests to it.
- Registers address, write data and RD/WR strobes toward memory; holds the strobes for a programmable number of wait states; captures read data; returns a one-cycle completion pulse.
- Rejects misaligned or malformed requests before they reach memory.

Parameters:
- DATAWIDTH_BUS, 32, width of address and data buses.
- WAIT_STATES, 1, extra cycles the memory strobe is held beyond the first (range 0..15).
- TIMEOUT_CYCLES, 16, cycles allowed for MEM_ACK before an error (used only with the optional feature).

Ports:
- MEMORY_ACCESS_CLOCK_50  in  1  system clock; all state changes on its rising edge.
- MEMORY_ACCESS_RESET_InLow  in  1  asynchronous active-low reset.
- CPU_REQ_In  in  1  request strobe; sampled only in IDLE.
- CPU_RD_In  in  1  read request.
- CPU_WR_In  in  1  write request.
- CPU_ADDRESS_InBUS  in  DATAWIDTH_BUS  byte address.
- CPU_data_InBUS  in  DATAWIDTH_BUS  write data.
- CPU_data_OutBUS  out  DATAWIDTH_BUS  last read data (registered).
- CPU_DONE_Out  out  1  one-cycle completion pulse.
- CPU_ERROR_Out  out  1  qualifies CPU_DONE_Out; high means the access failed.
- CPU_BUSY_Out  out  1  high in every state except IDLE.
- MEM_ADDRESS_OutBUS  out  DATAWIDTH_BUS  to MAIN_MEMORY address.
- MEM_data_OutBUS  out  DATAWIDTH_BUS  to MAIN_MEMORY write data.
- MEM_RD_Out  out  1  to MAIN_MEMORY read strobe.
- MEM_WR_Out  out  1  to MAIN_MEMORY write strobe.
- MEM_data_InBUS  in  DATAWIDTH_BUS  from MAIN_MEMORY read data.
- MEM_ACK_In  in  1  from MAIN_MEMORY acknowledge.

Behaviour:
- Reset (asynchronous, any state): state returns to IDLE and the wait counter clears; every output goes to 0, including CPU_data_OutBUS.
- States: IDLE, ACCESS, DONE, ERR.
- IDLE, CPU_REQ_In=1:
  - Exactly one of RD/WR set and ADDRESS[1:0]=00: latch address, data and operation; go to ACCESS.
  - RD and WR both or neither set, or ADDRESS[1:0]≠00: go to ERR; memory strobes never assert.
- ACCESS:
  - MEM_ADDRESS/MEM_data/MEM_RD or MEM_WR are registered and stable for exactly WAIT_STATES+1 cycles; counter counts 0..WAIT_STATES.
  - On the last ACCESS cycle, a read captures MEM_data_InBUS into CPU_data_OutBUS.
  - Next state is DONE.
- DONE: strobes deassert, CPU_DONE_Out=1, CPU_ERROR_Out=0; next state IDLE.
- ERR: CPU_DONE_Out=1, CPU_ERROR_Out=1, CPU_data_OutBUS unchanged; next state IDLE.
- Latency: request sampled at edge N, DONE high during cycle N+WAIT_STATES+2. Back-to-back requests need at least one IDLE cycle.
- CPU_REQ_In and its operands are ignored while BUSY. The CPU may drop REQ after the sampling edge.
- Writes never modify CPU_data_OutBUS.
- MEM_ADDRESS_OutBUS holds its last value in IDLE; only strobe levels matter to memory.
- Reset asserted mid-ACCESS: strobes drop asynchronously; no DONE pulse is issued for the aborted access.

Optional Feature:
- Macro: MEMORY_ACCESS_ACK_EN.
- Defined:
  - ACCESS holds the strobes until MEM_ACK_In=1 is sampled, but never for fewer than WAIT_STATES+1 cycles.
  - Read data is captured on the ACK cycle, then the FSM goes to DONE.
  - If TIMEOUT_CYCLES elapse without ACK, the FSM goes to ERR and CPU_data_OutBUS is cleared to 0.
- Undefined: MEM_ACK_In is unused and completion is purely by wait-state count.

Decomposition:
- Package memory_access_pkg: state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2, ERR=2'd3), operation enum (OP_RD, OP_WR), default constants for WAIT_STATES and TIMEOUT_CYCLES.
- One natural sub-module, memory_access_wait_counter:
  - Loadable down-counter with terminal-count output.
  - Shared between the wait-state count and the timeout count.

Test Plan:
- Read 0x00000800, WAIT_STATES=1, paired with MAIN_MEMORY -> MEM_RD high for 2 cycles; DONE high 3 cycles after the request edge; CPU_data_OutBUS=0xC6002001; ERROR=0.
- Read 0x00000000 then, after 1 idle cycle, write 0x00000804 with data 0xDEADBEEF:
  - Read -> CPU_data_OutBUS=0x10800800.
  - Write -> MEM_WR high 2 cycles with MEM_data_OutBUS=0xDEADBEEF; CPU_data_OutBUS stays 0x10800800.
- Misaligned read 0x00000802 -> ERR path, DONE+ERROR one cycle after the request, MEM_RD never asserts; same response for RD=WR=1 at 0x800.
- REQ pulsed again during ACCESS with a different address -> ignored; only one DONE; MEM_ADDRESS_OutBUS stays 0x800 throughout.
- Reset low for 1 cycle in the middle of ACCESS -> MEM_RD drops immediately, all outputs 0, no DONE; the next request completes normally.
- With MEMORY_ACCESS_ACK_EN:
  - ACK tied 0 -> DONE+ERROR after TIMEOUT_CYCLES=16 cycles, CPU_data_OutBUS=0.
  - ACK raised on the 4th ACCESS cycle -> data captured that cycle, DONE the next cycle.
